// File: rtl/fetch_controller.sv
// Fetch sequencing: memory handshake, IF freeze, branch redirect and flushes.
// A branch that cannot be taken yet is parked in a pending register.
module fetch_controller #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hazard_stall,
    input  logic              mem_stall,
    input  logic              branch_taken_ex,
    input  logic [ADDR_W-1:0] branch_addr_ex,
    input  logic              imem_ready,
    output logic              imem_req,
    output logic              freeze,
    output logic              branch_taken,
    output logic [ADDR_W-1:0] branch_addr,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              inst_valid,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FETCH    = 2'd1;
    localparam logic [1:0] HOLD     = 2'd2;
    localparam logic [1:0] REDIRECT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic              pend_valid;
    logic              pend_valid_nx;
    logic [ADDR_W-1:0] pend_addr;
    logic [ADDR_W-1:0] pend_addr_nx;
    logic [ADDR_W-1:0] tgt;
    logic              rr;
    logic              adv;
    logic              cnt_en;
    logic [CNT_W-1:0]  cnt;

    assign rr  = branch_taken_ex | pend_valid;
    assign tgt = branch_taken_ex ? branch_addr_ex : pend_addr;
    assign adv = !hazard_stall && !mem_stall;

    always_comb begin
        state_nx      = state;
        pend_valid_nx = pend_valid;
        pend_addr_nx  = pend_addr;
        imem_req      = 1'b0;
        freeze        = 1'b1;
        branch_taken  = 1'b0;
        branch_addr   = '0;
        flush_ifid    = 1'b0;
        flush_idex    = 1'b0;
        inst_valid    = 1'b0;
        if (rst) begin
            state_nx      = IDLE;
            pend_valid_nx = 1'b0;
            pend_addr_nx  = '0;
        end else begin
            unique case (state)
                IDLE, REDIRECT: begin
                    state_nx = FETCH;
                    if (branch_taken_ex) begin
                        pend_valid_nx = 1'b1;
                        pend_addr_nx  = branch_addr_ex;
                    end
                end
                FETCH, HOLD: begin
                    imem_req = (state == FETCH);
                    if (rr && !mem_stall) begin
                        branch_taken  = 1'b1;
                        branch_addr   = tgt;
                        freeze        = 1'b0;
                        flush_ifid    = 1'b1;
                        flush_idex    = 1'b1;
                        pend_valid_nx = 1'b0;
                        state_nx      = REDIRECT;
                    end else if (rr) begin
                        // mem_stall blocks the redirect; park the newest target
                        pend_valid_nx = 1'b1;
                        pend_addr_nx  = tgt;
                    end else if (state == HOLD) begin
                        if (adv) begin
                            freeze     = 1'b0;
                            inst_valid = 1'b1;
                            state_nx   = FETCH;
                        end
                    end else if (imem_ready) begin
                        if (adv) begin
                            freeze     = 1'b0;
                            inst_valid = 1'b1;
                        end else begin
                            state_nx = HOLD;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign cnt_en      = freeze && (state == FETCH || state == HOLD);
    assign stall_count = rst ? '0 : cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            cnt        <= '0;
        end else begin
            state      <= state_nx;
            pend_valid <= pend_valid_nx;
            pend_addr  <= pend_addr_nx;
            if (cnt_en && cnt != '1)
                cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard_stall;
    logic        mem_stall;
    logic        branch_taken_ex;
    logic [31:0] branch_addr_ex;
    logic        imem_ready;

    logic        imem_req, freeze, branch_taken, flush_ifid, flush_idex, inst_valid;
    logic [31:0] branch_addr;
    logic [15:0] stall_count;

    logic        imem_req4, freeze4, branch_taken4, flush_ifid4, flush_idex4, inst_valid4;
    logic [31:0] branch_addr4;
    logic [3:0]  stall_count4;

    always #5 clk = ~clk;

    fetch_controller #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .mem_stall(mem_stall),
        .branch_taken_ex(branch_taken_ex), .branch_addr_ex(branch_addr_ex),
        .imem_ready(imem_ready), .imem_req(imem_req), .freeze(freeze),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .inst_valid(inst_valid), .stall_count(stall_count)
    );

    fetch_controller #(.ADDR_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .mem_stall(mem_stall),
        .branch_taken_ex(branch_taken_ex), .branch_addr_ex(branch_addr_ex),
        .imem_ready(imem_ready), .imem_req(imem_req4), .freeze(freeze4),
        .branch_taken(branch_taken4), .branch_addr(branch_addr4),
        .flush_ifid(flush_ifid4), .flush_idex(flush_idex4),
        .inst_valid(inst_valid4), .stall_count(stall_count4)
    );

    typedef struct packed {
        logic        req;
        logic        frz;
        logic        bt;
        logic [31:0] ba;
        logic        fl;
        logic        iv;
        logic [15:0] sc;
        logic [3:0]  sc4;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("imem_req", {31'd0, imem_req}, {31'd0, e.req});
            chk("freeze", {31'd0, freeze}, {31'd0, e.frz});
            chk("branch_taken", {31'd0, branch_taken}, {31'd0, e.bt});
            chk("branch_addr", branch_addr, e.ba);
            chk("flush_ifid", {31'd0, flush_ifid}, {31'd0, e.fl});
            chk("flush_idex", {31'd0, flush_idex}, {31'd0, e.fl});
            chk("inst_valid", {31'd0, inst_valid}, {31'd0, e.iv});
            chk("stall_count", {16'd0, stall_count}, {16'd0, e.sc});
            chk("stall_count4", {28'd0, stall_count4}, {28'd0, e.sc4});
            chk("branch_taken4", {31'd0, branch_taken4}, {31'd0, e.bt});
        end
    end

    // inputs: r hz ms bte bae rdy | expected: req frz bt ba fl iv | inc = counted cycle
    task automatic step(
        input logic r, input logic hz, input logic ms, input logic bte,
        input logic [31:0] bae, input logic rdy,
        input logic e_req, input logic e_frz, input logic e_bt,
        input logic [31:0] e_ba, input logic e_fl, input logic e_iv, input logic inc
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        hazard_stall = hz;
        mem_stall = ms;
        branch_taken_ex = bte;
        branch_addr_ex = bae;
        imem_ready = rdy;
        e.req = e_req;
        e.frz = e_frz;
        e.bt  = e_bt;
        e.ba  = e_ba;
        e.fl  = e_fl;
        e.iv  = e_iv;
        e.sc  = r ? 16'd0 : 16'(exp_cnt);
        e.sc4 = r ? 4'd0 : (exp_cnt > 15 ? 4'd15 : 4'(exp_cnt));
        q.push_back(e);
        if (r) exp_cnt = 0;
        else if (inc) exp_cnt++;
    endtask

    task automatic run_ok();
        step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        rst = 1'b1;
        hazard_stall = 1'b0;
        mem_stall = 1'b0;
        branch_taken_ex = 1'b0;
        branch_addr_ex = '0;
        imem_ready = 1'b0;

        // reset then steady fetch
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        run_ok();
        run_ok();
        run_ok();

        // memory wait then hazard
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        run_ok();

        // branch, no stall
        step(0, 0, 0, 1, 32'h40, 1, 1, 0, 1, 32'h40, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        run_ok();

        // branch during mem_stall
        step(0, 0, 1, 1, 32'h80, 1, 1, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h80, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        run_ok();
        run_ok();

        // overwrite of a parked branch
        step(0, 0, 1, 1, 32'h80, 1, 1, 1, 0, 0, 0, 0, 1);
        step(0, 0, 1, 1, 32'hC0, 1, 1, 1, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 1, 0, 1, 32'hC0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        run_ok();

        // branch together with hazard_stall
        step(0, 1, 0, 1, 32'h100, 1, 1, 0, 1, 32'h100, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        run_ok();

        // reset in the REDIRECT cycle drops a branch arriving there
        step(0, 0, 0, 1, 32'h200, 1, 1, 0, 1, 32'h200, 1, 0, 0);
        step(1, 0, 0, 1, 32'h300, 1, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        run_ok();
        run_ok();

        // 20 frozen cycles: 16-bit counter reaches 20, 4-bit one sticks at 15
        for (int i = 0; i < 20; i++)
            step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        run_ok();
        run_ok();

        repeat (3) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
